// File: rtl/seq_shift_add_multiplier.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : seq_shift_add_multiplier                                      |
// | Description : Iterative shift-and-add multiplier. It consumes BPC bits of   |
// |               the multiplier magnitude per cycle. Signed operands are       |
// |               handled as a magnitude product with a final conditional       |
// |               negate. The result is held until the consumer accepts it.     |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
module seq_shift_add_multiplier #(
  parameter  int A_W = 16,
  parameter  int B_W = 4,
  parameter  int BPC = 2,
  localparam int C_W = A_W + B_W
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_vld,
  output logic           in_rdy,
  input  logic [A_W-1:0] a,
  input  logic [B_W-1:0] b,
  input  logic           is_signed,
  output logic           out_vld,
  input  logic           out_rdy,
  output logic [C_W-1:0] c,
  output logic           busy
);

  // Worst-case number of compute steps, and a counter wide enough to reach it
  localparam int STEPS = (B_W + BPC - 1) / BPC;
  localparam int CNT_W = $clog2(STEPS + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [C_W-1:0]   mcand_q, mcand_d;   // shifted multiplicand magnitude
  logic [B_W-1:0]   rem_q,   rem_d;     // multiplier bits not yet consumed
  logic [C_W-1:0]   acc_q,   acc_d;     // magnitude accumulator
  logic             neg_q,   neg_d;     // final result must be negated
  logic [CNT_W-1:0] cnt_q,   cnt_d;     // steps completed
  logic [C_W-1:0]   c_q,     c_d;       // presented product

  // Operand magnitudes; negating the most-negative value yields 2^(W-1), which
  // is still representable as an unsigned W-bit number.
  logic [A_W-1:0] w_mag_a;
  logic [B_W-1:0] w_mag_b;
  logic [BPC-1:0] w_digit;
  logic [C_W-1:0] w_partial;

  assign w_mag_a   = (is_signed && a[A_W-1]) ? -a : a;
  assign w_mag_b   = (is_signed && b[B_W-1]) ? -b : b;
  assign w_digit   = rem_q[BPC-1:0];
  assign w_partial = mcand_q * {{(C_W-BPC){1'b0}}, w_digit};

  // State and datapath registers; reset aborts any operation in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      mcand_q <= '0;
      rem_q   <= '0;
      acc_q   <= '0;
      neg_q   <= 1'b0;
      cnt_q   <= '0;
      c_q     <= '0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      rem_q   <= rem_d;
      acc_q   <= acc_d;
      neg_q   <= neg_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
    end
  end

  // Next-state and datapath update: latch on accept, shift-add while computing
  always_comb begin
    state_d = state_q;
    mcand_d = mcand_q;
    rem_d   = rem_q;
    acc_d   = acc_q;
    neg_d   = neg_q;
    cnt_d   = cnt_q;
    c_d     = c_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_vld) begin
          mcand_d = {{B_W{1'b0}}, w_mag_a};
          rem_d   = w_mag_b;
          acc_d   = '0;
          neg_d   = is_signed & (a[A_W-1] ^ b[B_W-1]);
          cnt_d   = '0;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        acc_d   = acc_q + w_partial;
        mcand_d = mcand_q << BPC;
        rem_d   = rem_q >> BPC;
        cnt_d   = cnt_q + CNT_W'(1);
        // Stop early once no multiplier bits remain; negating zero yields zero
        if ((rem_d == '0) || (cnt_d == CNT_W'(STEPS))) begin
          c_d     = neg_q ? -acc_d : acc_d;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_rdy) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign in_rdy  = (state_q == S_IDLE);
  assign out_vld = (state_q == S_DONE);
  assign busy    = (state_q != S_IDLE);
  assign c       = c_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_shift_add_multiplier.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : tb_seq_shift_add_multiplier                                   |
// | Description : Self-checking bench for seq_shift_add_multiplier: directed    |
// |               corner cases plus randomized operands against an arithmetic   |
// |               reference model.                                              |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
module tb_seq_shift_add_multiplier #(
  parameter int BPC = 2
);
  localparam int A_W = 16;
  localparam int B_W = 4;
  localparam int C_W = A_W + B_W;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_vld;
  logic           in_rdy;
  logic [A_W-1:0] a;
  logic [B_W-1:0] b;
  logic           is_signed;
  logic           out_vld;
  logic           out_rdy;
  logic [C_W-1:0] c;
  logic           busy;

  int             n_vec = 0;
  int             n_err = 0;
  logic [C_W-1:0] exp_c;
  logic           exp_armed = 1'b0;
  logic [A_W-1:0] cur_a;
  logic [B_W-1:0] cur_b;
  logic           cur_s;

  seq_shift_add_multiplier #(.A_W(A_W), .B_W(B_W), .BPC(BPC)) dut (
    .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .in_rdy(in_rdy),
    .a(a), .b(b), .is_signed(is_signed), .out_vld(out_vld),
    .out_rdy(out_rdy), .c(c), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference product: plain integer multiply, truncated to the product width
  function automatic logic [C_W-1:0] ref_prod(input logic [A_W-1:0] fa,
                                               input logic [B_W-1:0] fb,
                                               input logic fs);
    longint pa, pb, p;
    pa = fs ? longint'($signed(fa)) : longint'(fa);
    pb = fs ? longint'($signed(fb)) : longint'(fb);
    p  = pa * pb;
    return p[C_W-1:0];
  endfunction

  // Reference step count: max(1, ceil(L/BPC)), L = bit length of |b|
  function automatic int ref_steps(input logic [B_W-1:0] fb, input logic fs);
    longint mag;
    int     len, n;
    mag = fs ? longint'($signed(fb)) : longint'(fb);
    if (mag < 0) mag = -mag;
    len = 0;
    for (int i = 0; i < 32; i++) if (((mag >> i) & 1) != 0) len = i + 1;
    n = (len + BPC - 1) / BPC;
    return (n < 1) ? 1 : n;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (a=0x%0h b=0x%0h s=%0d)",
               nm, act, req, cur_a, cur_b, cur_s);
    end
  endtask

  // Whenever a product is presented it must match the model, and only while
  // an operation is outstanding.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_vld === 1'b1) begin
      n_vec++;
      if (!exp_armed) begin
        n_err++;
        $display("FAIL stale_out_vld: got out_vld=1 c=0x%0h, expected out_vld=0", c);
      end else if (c !== exp_c) begin
        n_err++;
        $display("FAIL product: got c=0x%0h, expected 0x%0h (a=0x%0h b=0x%0h s=%0d)",
                 c, exp_c, cur_a, cur_b, cur_s);
      end
    end
  end

  // One complete transaction with hold cycles of back-pressure in DONE
  task automatic run_op(input logic [A_W-1:0] ta, input logic [B_W-1:0] tb,
                        input logic ts, input int hold,
                        input bit use_lit, input logic [C_W-1:0] lit_c);
    int edges;
    int exp_n;
    @(negedge clk);
    cur_a = ta; cur_b = tb; cur_s = ts;
    a = ta; b = tb; is_signed = ts; in_vld = 1'b1; out_rdy = 1'b0;
    chk("in_rdy_idle", 32'(in_rdy), 32'd1);
    exp_c = ref_prod(ta, tb, ts);
    exp_n = ref_steps(tb, ts);
    if (use_lit) chk("literal_c_model", 32'(exp_c), 32'(lit_c));
    @(posedge clk); #1;
    exp_armed = 1'b1;
    // Scramble operands after acceptance; request stays asserted to be ignored
    a = A_W'($urandom); b = B_W'($urandom); is_signed = 1'($urandom);
    edges = 0;
    while (!out_vld && edges < 40) begin
      chk("busy_calc", 32'(busy), 32'd1);
      chk("in_rdy_calc", 32'(in_rdy), 32'd0);
      @(posedge clk); #1;
      edges++;
    end
    if (!out_vld) begin
      n_vec++; n_err++;
      $display("FAIL timeout: got no out_vld after %0d edges, expected %0d", edges, exp_n);
    end else begin
      chk("latency", 32'(edges), 32'(exp_n));
      if (use_lit) chk("literal_c_dut", 32'(c), 32'(lit_c));
    end
    for (int k = 0; k < hold; k++) begin
      chk("done_vld", 32'(out_vld), 32'd1);
      chk("done_c", 32'(c), 32'(exp_c));
      chk("done_in_rdy", 32'(in_rdy), 32'd0);
      a = A_W'($urandom); b = B_W'($urandom); is_signed = 1'($urandom);
      @(posedge clk); #1;
    end
    out_rdy = 1'b1;
    @(posedge clk); #1;
    out_rdy = 1'b0; in_vld = 1'b0; exp_armed = 1'b0;
    chk("post_vld", 32'(out_vld), 32'd0);
    chk("post_in_rdy", 32'(in_rdy), 32'd1);
    chk("post_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    chk("single_handshake", 32'(out_vld), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; in_vld = 1'b0; out_rdy = 1'b0;
    a = '0; b = '0; is_signed = 1'b0;
    cur_a = '0; cur_b = '0; cur_s = 1'b0;
    #2;
    chk("rst_in_rdy", 32'(in_rdy), 32'd1);
    chk("rst_out_vld", 32'(out_vld), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_c", 32'(c), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Directed corner cases with hand-computed products
    run_op(16'h0004, 4'h5, 1'b0, 0, 1'b1, 20'h00014);
    run_op(16'hFFFF, 4'h0, 1'b0, 1, 1'b1, 20'h00000);
    run_op(16'h8000, 4'hF, 1'b1, 0, 1'b1, 20'h08000);
    run_op(16'h0003, 4'hE, 1'b1, 0, 1'b1, 20'hFFFFA);
    run_op(16'h0000, 4'hF, 1'b1, 0, 1'b1, 20'h00000);
    run_op(16'h8000, 4'h8, 1'b1, 2, 1'b1, 20'h40000);
    run_op(16'hFFFF, 4'hF, 1'b0, 5, 1'b1, 20'hEFFF1);

    // Reset in the middle of a computation aborts it
    @(negedge clk);
    cur_a = 16'h0007; cur_b = 4'hF; cur_s = 1'b0;
    a = 16'h0007; b = 4'hF; is_signed = 1'b0; in_vld = 1'b1;
    @(posedge clk); #1;
    in_vld = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_out_vld", 32'(out_vld), 32'd0);
    chk("abort_in_rdy", 32'(in_rdy), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_c", 32'(c), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_op(16'h1234, 4'h3, 1'b0, 0, 1'b1, 20'h0369C);
    repeat (4) begin
      @(posedge clk); #1;
      chk("idle_after_abort", 32'(out_vld), 32'd0);
    end

    // Randomized operands, signedness and back-pressure
    for (int i = 0; i < 400; i++) begin
      logic [A_W-1:0] ra;
      logic [B_W-1:0] rb;
      ra = A_W'($urandom);
      rb = B_W'($urandom);
      if (i % 8 == 0) ra = 16'h8000;
      if (i % 8 == 1) ra = 16'hFFFF;
      if (i % 8 == 2) ra = 16'h0000;
      run_op(ra, rb, 1'($urandom), int'($urandom_range(0, 3)), 1'b0, '0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
